// File: rtl/adder_tree_acc_pipe.sv
// Fully pipelined adder tree with a packet accumulator on the back end.
// Build macro ADDER_TREE_ACC_SAT_EN: clamp on overflow instead of wrapping modulo 2^OUT_WIDTH.
module adder_tree_acc_pipe #(
    parameter int NUM_INPUTS = 16,
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 24,
    parameter int SIGNED     = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic                           in_last,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0] in_data,
    output logic                           out_valid,
    output logic [OUT_WIDTH-1:0]           out_data,
    output logic                           out_overflow
);

    localparam int   S   = $clog2(NUM_INPUTS);
    localparam int   TW  = IN_WIDTH + S;
    localparam logic SGN = (SIGNED != 0);

    // Streaming handshake: a beat transfers on every rising edge with in_valid high; there is
    // no ready, so the source is never stalled. out_valid is a single-cycle strobe per packet.

    // Tree nodes are heap-indexed: node 1 is the root, node i adds children 2i and 2i+1, and
    // indices >= NUM_INPUTS are the input lanes. Every node is held at the full tree width
    // with correct extension, so a node at depth d carries IN_WIDTH+(S-d) meaningful bits.
    logic [TW-1:0] leaf   [NUM_INPUTS];
    logic [TW-1:0] node_q [1:NUM_INPUTS-1];

    for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_leaf
        assign leaf[j] = {{S{SGN & in_data[j*IN_WIDTH+IN_WIDTH-1]}},
                          in_data[j*IN_WIDTH +: IN_WIDTH]};
    end

    for (genvar i = 1; i < NUM_INPUTS; i++) begin : g_node
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        if (2 * i >= NUM_INPUTS) begin : g_from_leaf
            assign a = leaf[2*i-NUM_INPUTS];
            assign b = leaf[2*i+1-NUM_INPUTS];
        end else begin : g_from_node
            assign a = node_q[2*i];
            assign b = node_q[2*i+1];
        end
        always_ff @(posedge clk) begin
            node_q[i] <= a + b;
        end
    end

    // One valid/last tag per tree stage; the data path itself carries no reset.
    logic [S-1:0] vld_q;
    logic [S-1:0] lst_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            lst_q[0] <= in_valid & in_last;
            for (int k = 1; k < S; k++) begin
                vld_q[k] <= vld_q[k-1];
                lst_q[k] <= lst_q[k-1];
            end
        end
    end

    logic                 tree_vld;
    logic                 tree_lst;
    logic [TW-1:0]        tree_sum;

    assign tree_vld = vld_q[S-1];
    assign tree_lst = lst_q[S-1];
    assign tree_sum = node_q[1];

    logic [OUT_WIDTH-1:0] acc_q;
    logic                 first_q;
    logic                 ovf_q;
    logic [OUT_WIDTH:0]   tree_ext;
    logic [OUT_WIDTH:0]   acc_ext;
    logic [OUT_WIDTH:0]   r_sum;
    logic                 beat_ovf;
    logic [OUT_WIDTH-1:0] result;

    // One guard bit above OUT_WIDTH exposes overflow of both unsigned and signed sums.
    assign tree_ext = {{(OUT_WIDTH+1-TW){SGN & tree_sum[TW-1]}}, tree_sum};
    assign acc_ext  = first_q ? '0 : {SGN & acc_q[OUT_WIDTH-1], acc_q};
    assign r_sum    = acc_ext + tree_ext;
    assign beat_ovf = SGN ? (r_sum[OUT_WIDTH] ^ r_sum[OUT_WIDTH-1]) : r_sum[OUT_WIDTH];

`ifdef ADDER_TREE_ACC_SAT_EN
    localparam logic [OUT_WIDTH-1:0] UMAX = '1;
    localparam logic [OUT_WIDTH-1:0] SMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // The guard bit holds the sign of the true sum, which picks the clamp direction.
    always_comb begin
        result = r_sum[OUT_WIDTH-1:0];
        if (beat_ovf) begin
            if (SGN) begin
                result = r_sum[OUT_WIDTH] ? SMIN : SMAX;
            end else begin
                result = UMAX;
            end
        end
    end
`else
    always_comb begin
        result = r_sum[OUT_WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            first_q      <= 1'b1;
            ovf_q        <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (tree_vld) begin
                if (tree_lst) begin
                    out_data     <= result;
                    out_overflow <= ovf_q | beat_ovf;
                    out_valid    <= 1'b1;
                    first_q      <= 1'b1;
                    ovf_q        <= 1'b0;
                end else begin
                    acc_q   <= result;
                    first_q <= 1'b0;
                    ovf_q   <= ovf_q | beat_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_acc_pipe.sv
// Bench for adder_tree_acc_pipe: three instances (24-bit unsigned, 12-bit unsigned, 24-bit signed)
// share one stimulus stream; results are checked against a queue of expected packet sums.
module tb_adder_tree_acc_pipe;

    localparam int N   = 16;
    localparam int W   = 8;
    localparam int DW  = N * W;
    localparam int LAT = 5;

`ifdef ADDER_TREE_ACC_SAT_EN
    localparam logic [23:0] NARROW_FF2 = 24'd4095;
    localparam logic [23:0] NARROW_802 = 24'd4095;
`else
    localparam logic [23:0] NARROW_FF2 = 24'd4064;
    localparam logic [23:0] NARROW_802 = 24'd0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_last;
    logic [DW-1:0] in_data;

    logic          vld0, vld1, vld2;
    logic          ovf0, ovf1, ovf2;
    logic [23:0]   dat0;
    logic [11:0]   dat1;
    logic [23:0]   dat2;

    logic [2:0]        out_valid;
    logic [2:0]        out_overflow;
    logic [2:0][23:0]  out_data;

    assign out_valid    = {vld2, vld1, vld0};
    assign out_overflow = {ovf2, ovf1, ovf0};
    assign out_data     = {dat2, {12'd0, dat1}, dat0};

    adder_tree_acc_pipe #(.NUM_INPUTS(N), .IN_WIDTH(W), .OUT_WIDTH(24), .SIGNED(0)) u_wide (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .out_valid(vld0), .out_data(dat0), .out_overflow(ovf0)
    );

    adder_tree_acc_pipe #(.NUM_INPUTS(N), .IN_WIDTH(W), .OUT_WIDTH(12), .SIGNED(0)) u_narrow (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .out_valid(vld1), .out_data(dat1), .out_overflow(ovf1)
    );

    adder_tree_acc_pipe #(.NUM_INPUTS(N), .IN_WIDTH(W), .OUT_WIDTH(24), .SIGNED(1)) u_signed (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .out_valid(vld2), .out_data(dat2), .out_overflow(ovf2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2:0][23:0] data;
        logic [2:0]       ovf;
        int               due;
    } exp_t;

    exp_t             exp_q [$];
    exp_t             mon_e;
    logic [2:0][23:0] last_exp;
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic check(input string nm, input int k, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got 0x%0h, expected 0x%0h", nm, k, cyc, act, exp);
        end
    endtask

    // Reference model: integer packet sums with range checks per instance.
    int     ow [3] = '{24, 12, 24};
    bit     sg [3] = '{1'b0, 1'b0, 1'b1};
    longint m_acc [3];
    bit     m_first [3];
    bit     m_ovf [3];

    task automatic reset_model();
        for (int k = 0; k < 3; k++) begin
            m_acc[k]   = 0;
            m_first[k] = 1'b1;
            m_ovf[k]   = 1'b0;
        end
        exp_q.delete();
        last_exp = '0;
    endtask

    task automatic model_beat(input logic [DW-1:0] d, input bit last, input bit use_tab,
                              input logic [2:0][23:0] td, input logic [2:0] tovf, input int due);
        exp_t e;
        e.data = '0;
        e.ovf  = '0;
        for (int k = 0; k < 3; k++) begin
            longint s, r, lo, hi, span;
            bit     bo;
            logic [7:0] ln;
            s = 0;
            for (int i = 0; i < N; i++) begin
                ln = d[i*W +: W];
                if (sg[k]) s += longint'($signed(ln));
                else       s += longint'(ln);
            end
            span = longint'(1) << ow[k];
            lo   = sg[k] ? -(span / 2) : 0;
            hi   = sg[k] ? (span / 2) - 1 : span - 1;
            r    = (m_first[k] ? 0 : m_acc[k]) + s;
            bo   = (r < lo) || (r > hi);
`ifdef ADDER_TREE_ACC_SAT_EN
            if (r > hi) r = hi;
            else if (r < lo) r = lo;
`else
            if (bo) begin
                r = r & (span - 1);
                if (sg[k] && r > hi) r -= span;
            end
`endif
            if (last) begin
                e.data[k]  = 24'(r & (span - 1));
                e.ovf[k]   = m_ovf[k] | bo;
                m_first[k] = 1'b1;
                m_ovf[k]   = 1'b0;
            end else begin
                m_acc[k]   = r;
                m_first[k] = 1'b0;
                m_ovf[k]   = m_ovf[k] | bo;
            end
        end
        if (last) begin
            if (use_tab) begin
                e.data = td;
                e.ovf  = tovf;
            end
            e.due = due;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    check("out_valid pulse", k, 24'(out_valid[k]), 24'd1);
                    check("out_data", k, out_data[k], mon_e.data[k]);
                    check("out_overflow", k, 24'(out_overflow[k]), 24'(mon_e.ovf[k]));
                    last_exp[k] = mon_e.data[k];
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    check("out_valid idle", k, 24'(out_valid[k]), 24'd0);
                    check("out_data hold", k, out_data[k], last_exp[k]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [DW-1:0] d, input bit last, input bit use_tab,
                              input logic [2:0][23:0] td, input logic [2:0] tovf);
        @(negedge clk);
        in_valid = 1'b1;
        in_last  = last;
        in_data  = d;
        model_beat(d, last, use_tab, td, tovf, cyc + LAT);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 3; k++) begin
            check("reset out_valid", k, 24'(out_valid[k]), 24'd0);
            check("reset out_data", k, out_data[k], 24'd0);
            check("reset out_overflow", k, 24'(out_overflow[k]), 24'd0);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int               nbeats;
        logic [2:0][7:0]  lane;
        int               gap_after;
        logic [2:0][23:0] exp_data;
        logic [2:0]       exp_ovf;
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input int nb, input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                           input int gap, input logic [23:0] e0, input logic [23:0] e1,
                           input logic [23:0] e2, input logic [2:0] o);
        vec_t v;
        v.nbeats    = nb;
        v.lane      = {l2, l1, l0};
        v.gap_after = gap;
        v.exp_data  = {e2, e1, e0};
        v.exp_ovf   = o;
        vecs.push_back(v);
    endtask

    initial begin
        logic [DW-1:0] d;
        int nb;

        // Each beat drives the same value on all 16 lanes; expected sums per instance.
        add_vec(1, 8'hFF, 8'h00, 8'h00, -1, 24'd4080, 24'd4080, 24'hFFFFF0, 3'b000);
        add_vec(3, 8'h01, 8'h02, 8'h03,  1, 24'd96,   24'd96,   24'd96,     3'b000);
        add_vec(1, 8'h01, 8'h00, 8'h00, -1, 24'd16,   24'd16,   24'd16,     3'b000);
        add_vec(1, 8'h02, 8'h00, 8'h00, -1, 24'd32,   24'd32,   24'd32,     3'b000);
        add_vec(2, 8'hFF, 8'hFF, 8'h00, -1, 24'd8160, NARROW_FF2, 24'hFFFFE0, 3'b010);
        add_vec(1, 8'h80, 8'h00, 8'h00, -1, 24'd2048, 24'd2048, 24'hFFF800, 3'b000);
        add_vec(3, 8'h00, 8'h00, 8'h00, -1, 24'd0,    24'd0,    24'd0,      3'b000);
        add_vec(2, 8'h07, 8'h09, 8'h00,  0, 24'd256,  24'd256,  24'd256,    3'b000);
        add_vec(2, 8'h80, 8'h80, 8'h00, -1, 24'd4096, NARROW_802, 24'hFFF000, 3'b010);
        add_vec(1, 8'h7F, 8'h00, 8'h00, -1, 24'd2032, 24'd2032, 24'd2032,   3'b000);

        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        reset_model();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        idle(2);

        // Table vectors run back to back, so consecutive single-beat packets have no gap.
        foreach (vecs[v]) begin
            for (int b = 0; b < vecs[v].nbeats; b++) begin
                drive_beat({N{vecs[v].lane[b]}}, b == vecs[v].nbeats - 1, 1'b1,
                           vecs[v].exp_data, vecs[v].exp_ovf);
                if (b == vecs[v].gap_after) idle(1);
            end
        end
        idle(8);

        // Reset two edges after a last beat is accepted: no pulse, outputs cleared.
        drive_beat({N{8'h05}}, 1'b1, 1'b0, '0, '0);
        idle(2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        reset_model();
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        idle(6);
        drive_beat({N{8'h03}}, 1'b0, 1'b1, '0, '0);
        drive_beat({N{8'h04}}, 1'b1, 1'b1, {24'd112, 24'd112, 24'd112}, 3'b000);
        idle(8);

        // Random packets with random bubbles, checked against the model.
        repeat (25) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                d = {$urandom(), $urandom(), $urandom(), $urandom()};
                drive_beat(d, b == nb - 1, 1'b0, '0, '0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(10);

        check("expected queue drained", 0, 24'(exp_q.size()), 24'd0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
